// File: rtl/err_sumup_fault_monitor_pkg.sv
// err_sumup_fault_monitor_pkg: shared state enum, default widths and saturating add
package err_sumup_fault_monitor_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, JUDGE, FAULT} state_e;
  localparam int DEF_INWIDTH = 26;
  localparam int DEF_ACCWIDTH = 32;
  localparam int DEF_WINW = 8;
  localparam int DEF_CNTW = 8;
  localparam int LIMW = 4;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] s;
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, m}) ? m : s[63:0];
  endfunction
endpackage

// File: rtl/err_sumup_fault_monitor_if.sv
// err_sumup_fault_monitor_if: summed error-check sample stream (data + enable)
interface err_sumup_fault_monitor_if import err_sumup_fault_monitor_pkg::*; #(
  parameter int INWIDTH = DEF_INWIDTH
) ();
  logic [INWIDTH-1:0] err_chk_sumup;
  logic err_chk_sumup_en;
  modport master(output err_chk_sumup, err_chk_sumup_en);
  modport slave(input err_chk_sumup, err_chk_sumup_en);
endinterface

// File: rtl/err_sumup_fault_monitor_sat_acc.sv
// sat_acc: window accumulator with clear > load > saturating add priority
module sat_acc import err_sumup_fault_monitor_pkg::*; #(
  parameter int INWIDTH = DEF_INWIDTH,
  parameter int ACCWIDTH = DEF_ACCWIDTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                ld,
  input  logic                add,
  input  logic [INWIDTH-1:0]  din,
  output logic [ACCWIDTH-1:0] acc
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) acc <= '0;
    else if (clr) acc <= '0;
    else if (ld) acc <= ACCWIDTH'(din);
    else if (add) acc <= ACCWIDTH'(sat_add(64'(acc), 64'(din), ACCWIDTH));
endmodule

// File: rtl/err_sumup_fault_monitor.sv
// err_sumup_fault_monitor: windowed sumup accumulation, threshold judge and sticky consecutive-exceed fault
module err_sumup_fault_monitor import err_sumup_fault_monitor_pkg::*; #(
  parameter int INWIDTH = DEF_INWIDTH,
  parameter int ACCWIDTH = DEF_ACCWIDTH,
  parameter int WINW = DEF_WINW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                  clk,
  input  logic                  rstn,
  err_sumup_fault_monitor_if.slave sum_if,
  input  logic [ACCWIDTH-1:0]   thresh_i,
  input  logic [WINW-1:0]       win_len_i,
  input  logic [LIMW-1:0]       consec_lim_i,
  input  logic                  fault_ack_i,
  input  logic                  clear_i,
  output logic [ACCWIDTH-1:0]   win_sum_o,
  output logic                  win_done_o,
  output logic                  win_exceed_o,
  output logic                  fault_o,
  output logic [CNTW-1:0]       exceed_cnt_o,
  output logic                  busy_o
);
  state_e state;
  logic [WINW-1:0] cnt, len_q, len_eff;
  logic [LIMW-1:0] lim_q, lim_eff, consec, consec_nxt;
  logic [ACCWIDTH-1:0] thr_q, acc;
  logic en, exceed, trip, start;
  assign en = sum_if.err_chk_sumup_en;
  assign len_eff = (win_len_i == '0) ? WINW'(1) : win_len_i;
  assign lim_eff = (consec_lim_i == '0) ? LIMW'(1) : consec_lim_i;
  assign exceed = acc > thr_q;
  assign consec_nxt = exceed ? LIMW'(sat_add(64'(consec), 64'd1, LIMW)) : '0;
  assign trip = consec_nxt >= lim_q;
  // a window opens from IDLE, or straight out of a judge that did not trip
  assign start = en && (state == IDLE || (state == JUDGE && !trip));
  assign busy_o = state != IDLE;
  sat_acc #(.INWIDTH(INWIDTH), .ACCWIDTH(ACCWIDTH)) u_acc (
    .clk(clk),
    .rstn(rstn),
    .clr(clear_i),
    .ld(start),
    .add(state == ACCUM && en),
    .din(sum_if.err_chk_sumup),
    .acc(acc)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= WINW'(1);
      lim_q <= LIMW'(1);
      thr_q <= '0;
      consec <= '0;
      win_sum_o <= '0;
      win_done_o <= 1'b0;
      win_exceed_o <= 1'b0;
      fault_o <= 1'b0;
      exceed_cnt_o <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      cnt <= '0;
      consec <= '0;
      win_sum_o <= '0;
      win_done_o <= 1'b0;
      win_exceed_o <= 1'b0;
      fault_o <= 1'b0;
      exceed_cnt_o <= '0;
    end else begin
      win_done_o <= 1'b0;
      if (start) begin
        len_q <= len_eff;
        lim_q <= lim_eff;
        thr_q <= thresh_i;
        cnt <= WINW'(1);
      end
      case (state)
        IDLE: if (en) state <= (len_eff == WINW'(1)) ? JUDGE : ACCUM;
        ACCUM: if (en) begin
          cnt <= cnt + WINW'(1);
          if (cnt + WINW'(1) == len_q) state <= JUDGE;
        end
        JUDGE: begin
          win_sum_o <= acc;
          win_done_o <= 1'b1;
          win_exceed_o <= exceed;
          consec <= consec_nxt;
          if (exceed) exceed_cnt_o <= CNTW'(sat_add(64'(exceed_cnt_o), 64'd1, CNTW));
          if (trip) fault_o <= 1'b1;
          state <= trip ? FAULT : !en ? IDLE : (len_eff == WINW'(1)) ? JUDGE : ACCUM;
        end
        FAULT: if (fault_ack_i) begin
          fault_o <= 1'b0;
          consec <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
